// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle RV32I data-memory responder with byte/half/word
// loads and stores, misalignment rejection and a stall (busy) output.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  func3,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        misalign
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic           op_write;
    logic [AW+1:0]  addr_q;
    logic [31:0]    wdata_q;
    logic [2:0]     func3_q;
    logic [31:0]    mem [DEPTH_WORDS];

    logic           req;
    logic           req_legal;
    logic           access;
    logic [AW-1:0]  idx;
    logic [31:0]    word_rd;
    logic [31:0]    load_val;
    logic [31:0]    store_val;
    logic [7:0]     lane_b;
    logic [15:0]    lane_h;
    logic           addr_unused;

    // Upper address bits only alias onto the array.
    assign addr_unused = ^addr[31:AW+2];

    assign req     = mem_read | mem_write;
    assign idx     = addr_q[AW+1:2];
    assign word_rd = mem[idx];
    assign access  = (state == WAIT) && (cnt == '0);

    // Width/alignment legality of the incoming request; write wins when both set.
    always_comb begin
        req_legal = 1'b0;
        if (mem_write) begin
            case (func3)
                3'b000:  req_legal = 1'b1;
                3'b001:  req_legal = ~addr[0];
                3'b010:  req_legal = (addr[1:0] == 2'b00);
                default: req_legal = 1'b0;
            endcase
        end else begin
            case (func3)
                3'b000, 3'b100: req_legal = 1'b1;
                3'b001, 3'b101: req_legal = ~addr[0];
                3'b010:         req_legal = (addr[1:0] == 2'b00);
                default:        req_legal = 1'b0;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state plus combinational busy/done.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    busy      = 1'b1;
                    state_nxt = req_legal ? WAIT : RESP;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (cnt == '0) state_nxt = RESP;
            end
            RESP: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // busy is driven straight from the request inputs in IDLE, so it is
        // forced low while reset is held to keep every output quiet.
        busy = busy & rst_n;
    end

    // Load formatting from the addressed lane.
    always_comb begin
        lane_b = word_rd[{addr_q[1:0], 3'b000} +: 8];
        lane_h = addr_q[1] ? word_rd[31:16] : word_rd[15:0];
        case (func3_q)
            3'b000:  load_val = {{24{lane_b[7]}}, lane_b};
            3'b100:  load_val = {24'h000000, lane_b};
            3'b001:  load_val = {{16{lane_h[15]}}, lane_h};
            3'b101:  load_val = {16'h0000, lane_h};
            default: load_val = word_rd;
        endcase
    end

    // Store merge: replace only the addressed lanes.
    always_comb begin
        store_val = word_rd;
        case (func3_q[1:0])
            2'b00:   store_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01: begin
                if (addr_q[1]) store_val[31:16] = wdata_q[15:0];
                else           store_val[15:0]  = wdata_q[15:0];
            end
            default: store_val = wdata_q;
        endcase
    end

    // Request capture, wait counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            op_write <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            func3_q  <= '0;
            rdata    <= '0;
            misalign <= 1'b0;
        end else if (state == IDLE && req) begin
            op_write <= mem_write;
            addr_q   <= addr[AW+1:0];
            wdata_q  <= wdata;
            func3_q  <= func3;
            if (req_legal) begin
                cnt <= CNT_INIT;
            end else begin
                rdata    <= '0;
                misalign <= 1'b1;
            end
        end else if (state == WAIT) begin
            if (cnt != '0) begin
                cnt <= cnt - 1'b1;
            end else begin
                misalign <= 1'b0;
                if (!op_write) rdata <= load_val;
            end
        end
    end

    // Data array; contents are not reset.
    always_ff @(posedge clk) begin
        if (access && op_write) mem[idx] <= store_val;
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: scoreboard bench with a byte-addressed reference memory.
module tb_data_mem_ctrl;

    localparam int unsigned LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [31:0] addr, wdata;
    logic [2:0]  func3;
    logic [31:0] rdata;
    logic        busy, done, misalign;

    int unsigned vectors    = 0;
    int unsigned miscompares = 0;
    int unsigned cyc        = 0;

    typedef struct {
        logic        is_load;
        logic        illegal;
        logic [31:0] rdata;
        int unsigned start;
    } exp_t;

    exp_t        sb[$];
    logic [7:0]  mdl [logic [11:0]];

    data_mem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .wdata(wdata), .func3(func3), .rdata(rdata),
        .busy(busy), .done(done), .misalign(misalign)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Access size in bytes, 0 when the func3/op combination is illegal.
    function automatic int unsigned acc_size(input logic wr, input logic [2:0] f3);
        if (wr) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        case (f3)
            3'd0, 3'd4: return 1;
            3'd1, 3'd5: return 2;
            3'd2:       return 4;
            default:    return 0;
        endcase
    endfunction

    // Issue one request in an IDLE cycle and wait for its completion.
    task automatic issue(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] f3);
        exp_t        e;
        int unsigned sz;
        logic        legal;
        logic [31:0] v;
        logic [31:0] m;
        logic [11:0] k;
        bit          got;
        @(negedge clk);
        sz    = acc_size(wr, f3);
        legal = (sz != 0) && ((a % sz) == 0);
        e.is_load = !wr;
        e.illegal = !legal;
        e.rdata   = '0;
        e.start   = cyc;
        if (legal) begin
            if (wr) begin
                for (int i = 0; i < int'(sz); i++) begin
                    k = a[11:0] + 12'(i);
                    mdl[k] = d[8*i +: 8];
                end
            end else begin
                v = '0;
                for (int i = 0; i < int'(sz); i++) begin
                    k = a[11:0] + 12'(i);
                    v = v | (32'(mdl[k]) << (8*i));
                end
                if (!f3[2] && sz < 4 && v[8*sz-1]) begin
                    m = 32'hFFFF_FFFF << (8*sz);
                    v = v | m;
                end
                e.rdata = v;
            end
        end
        sb.push_back(e);
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        func3     = f3;
        #1;
        chk("busy_req", {31'd0, busy}, 32'd1);
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (done) got = 1'b1;
            else chk("busy_wait", {31'd0, busy}, 32'd1);
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        else      chk("busy_resp", {31'd0, busy}, 32'd0);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // Monitor: compare every completion against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("misalign", {31'd0, misalign}, {31'd0, e.illegal});
                    if (e.is_load || e.illegal) chk("rdata", rdata, e.rdata);
                    chk("latency", cyc - e.start, e.illegal ? 32'd1 : LAT + 1);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] op;
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        addr = '0; wdata = '0; func3 = '0;
        #12;
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_misalign", {31'd0, misalign}, 32'd0);
        rst_n = 1'b1;

        // Initialise the region used by loads.
        for (int i = 0; i < 64; i++) issue(1'b0, 1'b1, 32'(i * 4), $urandom, 3'd2);

        issue(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 3'd2);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
        issue(1'b0, 1'b1, 32'h13, 32'h80, 3'd0);
        issue(1'b1, 1'b0, 32'h13, 32'h0, 3'd0);
        issue(1'b1, 1'b0, 32'h13, 32'h0, 3'd4);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
        issue(1'b0, 1'b1, 32'h12, 32'h1234, 3'd1);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
        issue(1'b1, 1'b0, 32'h12, 32'h0, 3'd5);
        issue(1'b1, 1'b0, 32'h12, 32'h0, 3'd1);
        issue(1'b1, 1'b0, 32'h11, 32'h0, 3'd2);
        issue(1'b0, 1'b1, 32'h13, 32'hFFFF, 3'd1);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 3'd2);
        issue(1'b1, 1'b0, 32'h10, 32'h0, 3'd3);

        for (int i = 0; i < 150; i++) begin
            op = 2'($urandom_range(0, 2));
            issue(op != 2'd1, op != 2'd0, $urandom & 32'hFFFF_F0FF, $urandom, 3'($urandom));
        end

        // Store aborted by reset must not commit.
        issue(1'b0, 1'b1, 32'h20, 32'h11111111, 3'd2);
        issue(1'b1, 1'b0, 32'h20, 32'h0, 3'd2);
        @(negedge clk);
        mem_write = 1'b1; addr = 32'h20; wdata = 32'h22222222; func3 = 3'd2;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_misalign", {31'd0, misalign}, 32'd0);
        @(negedge clk);
        mem_write = 1'b0;
        #2 rst_n = 1'b1;
        issue(1'b1, 1'b0, 32'h20, 32'h0, 3'd2);

        // Both request bits: write wins; high address bits alias.
        issue(1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 3'd2);
        issue(1'b1, 1'b0, 32'h1030, 32'h0, 3'd2);

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
